// File: rtl/exec_line.sv
// Execution end of the instruction-line handshake: runs one-hot opcodes against
// a cell RAM with a data pointer and drives the console output/input handshakes.
module exec_line #(
    parameter int DEPTH  = 256,
    parameter int PTR_W  = 8,
    parameter int CELL_W = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [15:0]       Opcode,
    input  logic              OpcodeReady,
    output logic              OpcodeAck,
    output logic              DataZero,
    output logic [CELL_W-1:0] OutData,
    output logic              OutValid,
    input  logic              OutReady,
    input  logic [CELL_W-1:0] InData,
    input  logic              InValid,
    output logic              InReady,
    output logic              Busy,
    output logic              Halted,
    output logic              Err
);

    typedef enum logic [3:0] {
        S_CLEAR    = 4'd0,
        S_IDLE     = 4'd1,
        S_EXEC     = 4'd2,
        S_LOAD     = 4'd3,
        S_OUT_WAIT = 4'd4,
        S_IN_WAIT  = 4'd5,
        S_ACK      = 4'd6,
        S_ACK_WAIT = 4'd7,
        S_HALT     = 4'd8
    } state_t;

    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CELL_W-1:0] CELL_ONE = CELL_W'(1);

    // Legal means exactly one of the ten defined opcode bits and no reserved bit.
    function automatic logic op_legal(input logic [15:0] op);
        logic [9:0] lo;
        lo = op[9:0];
        return (op[15:10] == 6'd0) && (lo != 10'd0) && ((lo & (lo - 10'd1)) == 10'd0);
    endfunction

    state_t             state_q, state_d;
    logic [15:0]        op_q, op_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   clr_q, clr_d;
    logic [CELL_W-1:0]  cur_q, cur_d;
    logic [CELL_W-1:0]  out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;
    logic               ack_q, ack_d;
    logic               zero_q, zero_d;
    logic               busy_q, busy_d;
    logic               halted_q, halted_d;
    logic               err_q, err_d;

    logic [CELL_W-1:0]  mem_q [DEPTH];
    logic [CELL_W-1:0]  rd_q;
    logic               we_s;
    logic [PTR_W-1:0]   waddr_s;
    logic [PTR_W-1:0]   raddr_s;
    logic [CELL_W-1:0]  wdata_s;

    // Next-state, datapath and RAM port control.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        ptr_d       = ptr_q;
        clr_d       = clr_q;
        cur_d       = cur_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        halted_d    = halted_q;
        err_d       = err_q;
        we_s        = 1'b0;
        waddr_s     = ptr_q;
        raddr_s     = ptr_q;
        wdata_s     = cur_q;
        case (state_q)
            S_CLEAR: begin
                we_s    = 1'b1;
                waddr_s = clr_q;
                wdata_s = '0;
                clr_d   = clr_q + PTR_ONE;
                if (clr_q == PTR_LAST) state_d = S_IDLE;
                else                   state_d = S_CLEAR;
            end
            S_IDLE: begin
                if (OpcodeReady) begin
                    op_d    = Opcode;
                    state_d = S_EXEC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EXEC: begin
                state_d = S_ACK;
                case (op_q)
                    16'h0002: begin
                        cur_d   = cur_q + CELL_ONE;
                        we_s    = 1'b1;
                        wdata_s = cur_d;
                    end
                    16'h0004: begin
                        cur_d   = cur_q - CELL_ONE;
                        we_s    = 1'b1;
                        wdata_s = cur_d;
                    end
                    // Pointer moves read the new address now so LOAD can capture it.
                    16'h0008: begin
                        ptr_d   = ptr_q + PTR_ONE;
                        raddr_s = ptr_d;
                        state_d = S_LOAD;
                    end
                    16'h0010: begin
                        ptr_d   = ptr_q - PTR_ONE;
                        raddr_s = ptr_d;
                        state_d = S_LOAD;
                    end
                    16'h0080: begin
                        out_data_d  = cur_q;
                        out_valid_d = 1'b1;
                        state_d     = S_OUT_WAIT;
                    end
                    16'h0100: begin
                        in_ready_d = 1'b1;
                        state_d    = S_IN_WAIT;
                    end
                    16'h0200: halted_d = 1'b1;
                    default: begin
                        if (!op_legal(op_q)) err_d = 1'b1;
                        else                 err_d = err_q;
                    end
                endcase
            end
            S_LOAD: begin
                cur_d   = rd_q;
                state_d = S_ACK;
            end
            S_OUT_WAIT: begin
                if (out_valid_q && OutReady) begin
                    out_valid_d = 1'b0;
                    state_d     = S_ACK;
                end else begin
                    state_d = S_OUT_WAIT;
                end
            end
            S_IN_WAIT: begin
                if (InValid && in_ready_q) begin
                    cur_d      = InData;
                    we_s       = 1'b1;
                    wdata_s    = InData;
                    in_ready_d = 1'b0;
                    state_d    = S_ACK;
                end else begin
                    state_d = S_IN_WAIT;
                end
            end
            S_ACK: begin
                if (halted_q)         state_d = S_HALT;
                else if (OpcodeReady) state_d = S_ACK_WAIT;
                else                  state_d = S_IDLE;
            end
            S_ACK_WAIT: begin
                if (!OpcodeReady) state_d = S_IDLE;
                else              state_d = S_ACK_WAIT;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_CLEAR;
        endcase
        ack_d  = (state_d == S_ACK);
        zero_d = (cur_d == '0);
        busy_d = (state_d != S_IDLE) && (state_d != S_ACK_WAIT) && (state_d != S_HALT);
    end

    // Control and output registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= S_CLEAR;
            op_q        <= 16'h0000;
            ptr_q       <= '0;
            clr_q       <= '0;
            cur_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            ack_q       <= 1'b0;
            zero_q      <= 1'b1;
            busy_q      <= 1'b1;
            halted_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            ptr_q       <= ptr_d;
            clr_q       <= clr_d;
            cur_q       <= cur_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            ack_q       <= ack_d;
            zero_q      <= zero_d;
            busy_q      <= busy_d;
            halted_q    <= halted_d;
            err_q       <= err_d;
        end
    end

    // Cell RAM: one write port, one synchronous read port.
    always_ff @(posedge Clk) begin
        if (we_s && !Rst) mem_q[waddr_s] <= wdata_s;
        rd_q <= mem_q[raddr_s];
    end

    assign OpcodeAck = ack_q;
    assign DataZero  = zero_q;
    assign OutData   = out_data_q;
    assign OutValid  = out_valid_q;
    assign InReady   = in_ready_q;
    assign Busy      = busy_q;
    assign Halted    = halted_q;
    assign Err       = err_q;

endmodule

// File: tb/tb_exec_line.sv
// Self-checking bench for exec_line: directed vector table, hand-written
// corner sequences, and randomized opcodes against a cell/pointer model.
module tb_exec_line;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [15:0] Opcode = 16'h0000;
    logic        OpcodeReady = 1'b0;
    logic        OpcodeAck;
    logic        DataZero;
    logic [7:0]  OutData;
    logic        OutValid;
    logic        OutReady = 1'b0;
    logic [7:0]  InData = 8'h00;
    logic        InValid = 1'b0;
    logic        InReady;
    logic        Busy;
    logic        Halted;
    logic        Err;

    int n_tests = 0;
    int n_fail  = 0;

    exec_line #(.DEPTH(256), .PTR_W(8), .CELL_W(8)) dut (
        .Clk(Clk), .Rst(Rst), .Opcode(Opcode), .OpcodeReady(OpcodeReady),
        .OpcodeAck(OpcodeAck), .DataZero(DataZero), .OutData(OutData),
        .OutValid(OutValid), .OutReady(OutReady), .InData(InData),
        .InValid(InValid), .InReady(InReady), .Busy(Busy), .Halted(Halted), .Err(Err)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [15:0] op;
        int          ostall;
        int          istall;
        logic [7:0]  ival;
        int          hold;
        int          lat;
        logic        zero;
        logic        err;
        logic [7:0]  out;
    } vec_t;

    vec_t vecs [23];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Issue one opcode and follow it to its Ack; handshakes driven with given stalls.
    task automatic run_op(input logic [15:0] op, input int ostall, input int istall,
                          input logic [7:0] ival, input int hold,
                          output int lat, output logic zero, output logic [7:0] odata,
                          output logic ostable, output int extra);
        logic seen;
        @(negedge Clk);
        Opcode = op; OpcodeReady = 1'b1; InData = ival; InValid = 1'b0; OutReady = 1'b0;
        lat = -1; zero = 1'b0; odata = 8'h00; ostable = 1'b1; extra = 0; seen = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge Clk);
            if (OutValid) begin
                if (!seen) odata = OutData;
                else if (OutData != odata) ostable = 1'b0;
                seen = 1'b1;
            end
            OutReady = (k >= 2 + ostall);
            InValid  = (k >= 2 + istall);
            if (OpcodeAck) begin
                lat  = k;
                zero = DataZero;
                break;
            end
        end
        OutReady = 1'b0; InValid = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(negedge Clk);
            if (OpcodeAck) extra++;
        end
        OpcodeReady = 1'b0;
    endtask

    // Apply reset (optionally with OpcodeReady asserted) and time the CLEAR sweep.
    task automatic reset_clear(input logic ready_during);
        int busy_cnt, acks;
        @(negedge Clk);
        Rst = 1'b1; Opcode = 16'h0001; OpcodeReady = ready_during;
        OutReady = 1'b0; InValid = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        chk("rst Busy", Busy, 1);
        chk("rst DataZero", DataZero, 1);
        chk("rst OpcodeAck", OpcodeAck, 0);
        chk("rst OutValid", OutValid, 0);
        chk("rst InReady", InReady, 0);
        chk("rst Halted", Halted, 0);
        chk("rst Err", Err, 0);
        busy_cnt = 0; acks = 0;
        for (int k = 0; k < 400; k++) begin
            if (!Busy) break;
            busy_cnt++;
            if (OpcodeAck) acks++;
            @(negedge Clk);
        end
        OpcodeReady = 1'b0;
        chk("clear busy cycles", busy_cnt, 256);
        chk("clear acks", acks, 0);
        chk("clear DataZero", DataZero, 1);
    endtask

    initial begin
        int          lat, extra, acks;
        logic        zero, ostable, legal, ok;
        logic [7:0]  odata, ival;
        logic [15:0] op;
        logic [7:0]  m [256];
        int          mp, ostall, istall, elat, kind;
        logic        merr;
        logic [7:0]  eout;

        vecs[0]  = '{16'h0004, 0, 0, 8'h00, 0, 2, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{16'h0002, 0, 0, 8'h00, 0, 2, 1'b1, 1'b0, 8'h00};
        vecs[2]  = '{16'h0010, 0, 0, 8'h00, 0, 3, 1'b1, 1'b0, 8'h00};
        vecs[3]  = '{16'h0002, 0, 0, 8'h00, 0, 2, 1'b0, 1'b0, 8'h00};
        for (int i = 4; i <= 9; i++)
            vecs[i] = '{16'h0008, 0, 0, 8'h00, 0, 3, 1'b1, 1'b0, 8'h00};
        vecs[10] = '{16'h0100, 0, 0, 8'h07, 0, 3, 1'b0, 1'b0, 8'h00};
        vecs[11] = '{16'h0008, 0, 0, 8'h00, 0, 3, 1'b1, 1'b0, 8'h00};
        vecs[12] = '{16'h0010, 0, 0, 8'h00, 0, 3, 1'b0, 1'b0, 8'h00};
        vecs[13] = '{16'h0080, 4, 0, 8'h00, 0, 7, 1'b0, 1'b0, 8'h07};
        vecs[14] = '{16'h0100, 0, 3, 8'h41, 0, 6, 1'b0, 1'b0, 8'h00};
        vecs[15] = '{16'h0006, 0, 0, 8'h00, 0, 2, 1'b0, 1'b1, 8'h00};
        vecs[16] = '{16'h0002, 0, 0, 8'h00, 5, 2, 1'b0, 1'b1, 8'h00};
        vecs[17] = '{16'h0004, 0, 0, 8'h00, 0, 2, 1'b0, 1'b1, 8'h00};
        vecs[18] = '{16'h0080, 0, 0, 8'h00, 0, 3, 1'b0, 1'b1, 8'h41};
        vecs[19] = '{16'h0020, 0, 0, 8'h00, 0, 2, 1'b0, 1'b1, 8'h00};
        vecs[20] = '{16'h0000, 0, 0, 8'h00, 0, 2, 1'b0, 1'b1, 8'h00};
        vecs[21] = '{16'h0400, 0, 0, 8'h00, 0, 2, 1'b0, 1'b1, 8'h00};
        vecs[22] = '{16'h0100, 0, 1, 8'h00, 0, 4, 1'b1, 1'b1, 8'h00};

        reset_clear(1'b1);

        for (int i = 0; i < 23; i++) begin
            run_op(vecs[i].op, vecs[i].ostall, vecs[i].istall, vecs[i].ival, vecs[i].hold,
                   lat, zero, odata, ostable, extra);
            chk($sformatf("vec%0d latency", i), lat, vecs[i].lat);
            chk($sformatf("vec%0d DataZero", i), zero, vecs[i].zero);
            chk($sformatf("vec%0d Err", i), Err, vecs[i].err);
            if (vecs[i].op == 16'h0080) begin
                chk($sformatf("vec%0d OutData", i), odata, vecs[i].out);
                chk($sformatf("vec%0d OutData stable", i), ostable, 1);
            end
            if (vecs[i].hold > 0) chk($sformatf("vec%0d extra acks", i), extra, 0);
        end

        // Reset while an OUT is stalled in its handshake.
        @(negedge Clk);
        Opcode = 16'h0080; OpcodeReady = 1'b1; OutReady = 1'b0;
        ok = 1'b0; acks = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge Clk);
            if (OpcodeAck) acks++;
            if (OutValid) begin ok = 1'b1; break; end
        end
        chk("abort OutValid raised", ok, 1);
        Rst = 1'b1; OpcodeReady = 1'b0;
        @(negedge Clk);
        chk("abort OutValid dropped", OutValid, 0);
        chk("abort no ack", acks + int'(OpcodeAck), 0);
        chk("abort Busy", Busy, 1);
        reset_clear(1'b0);

        // Randomized opcodes against the cell/pointer model.
        for (int i = 0; i < 256; i++) m[i] = 8'h00;
        mp = 0; merr = 1'b0;
        for (int t = 0; t < 80; t++) begin
            kind   = $urandom_range(0, 9);
            ostall = $urandom_range(0, 3);
            istall = $urandom_range(0, 3);
            ival   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            case (kind)
                0: op = 16'h0002;
                1: op = 16'h0004;
                2: op = 16'h0008;
                3: op = 16'h0010;
                4: op = 16'h0080;
                5: op = 16'h0100;
                6: op = 16'h0001;
                7: op = 16'h0020;
                8: op = 16'h0040;
                default: op = ($urandom_range(0, 1) == 0) ? (16'h8000 | 16'($urandom))
                                                         : 16'h0003 << $urandom_range(0, 8);
            endcase
            legal = ($countones(op) == 1) && (op[15:10] == 6'd0);
            elat = 2; eout = 8'h00;
            if (!legal) merr = 1'b1;
            else if (op == 16'h0002) m[mp] = m[mp] + 8'd1;
            else if (op == 16'h0004) m[mp] = m[mp] - 8'd1;
            else if (op == 16'h0008) begin mp = (mp + 1) % 256; elat = 3; end
            else if (op == 16'h0010) begin mp = (mp + 255) % 256; elat = 3; end
            else if (op == 16'h0080) begin eout = m[mp]; elat = 3 + ostall; end
            else if (op == 16'h0100) begin m[mp] = ival; elat = 3 + istall; end
            else elat = 2;
            run_op(op, ostall, istall, ival, 0, lat, zero, odata, ostable, extra);
            chk($sformatf("rand%0d op %h latency", t, op), lat, elat);
            chk($sformatf("rand%0d op %h DataZero", t, op), zero, int'(m[mp] == 8'h00));
            chk($sformatf("rand%0d op %h Err", t, op), Err, merr);
            if (op == 16'h0080) begin
                chk($sformatf("rand%0d OutData", t), odata, eout);
                chk($sformatf("rand%0d OutData stable", t), ostable, 1);
            end
        end

        // HALT is acked once; later opcodes are never accepted.
        run_op(16'h0200, 0, 0, 8'h00, 0, lat, zero, odata, ostable, extra);
        chk("halt latency", lat, 2);
        chk("halt Halted", Halted, 1);
        @(negedge Clk);
        Opcode = 16'h0002; OpcodeReady = 1'b1; acks = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge Clk);
            if (OpcodeAck) acks++;
        end
        OpcodeReady = 1'b0;
        chk("halt later acks", acks, 0);
        chk("halt Busy", Busy, 0);
        chk("halt Halted sticky", Halted, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
